jp_scan_ctrl: RTL and testbench

Scan sequencer for the two serial NES joypad ports. It generates the latch/clock waveform on the controller wires, deserialises both data lines in parallel, and publishes active-high 8-bit button states with a one-cycle valid strobe. It runs on demand or free-running, and feeds the CPU-side joypad MMR block.

---
 rtl/jp_scan_if.sv | 23 ++
 rtl/jp_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_jp_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jp_scan_if.sv
// Joypad scan controller bus: request/mode inputs, controller wires and published button states.
interface jp_scan_if;
  logic       scan_req;
  logic       auto_en;
  logic       jp_data1;
  logic       jp_data2;
  logic       jp_latch;
  logic       jp_clk;
  logic [7:0] jp1_state;
  logic [7:0] jp2_state;
  logic       state_vld;
  logic       busy;

  modport master (
    output scan_req, auto_en, jp_data1, jp_data2,
    input  jp_latch, jp_clk, jp1_state, jp2_state, state_vld, busy
  );

  modport slave (
    input  scan_req, auto_en, jp_data1, jp_data2,
    output jp_latch, jp_clk, jp1_state, jp2_state, state_vld, busy
  );
endinterface

// File: rtl/jp_scan_ctrl.sv
// NES dual-joypad scan sequencer: latch/clock generation, parallel deserialise, state publish.
// Optional JP_SCAN_DEBOUNCE_EN: publish a port only when two consecutive scans agree.
module jp_scan_ctrl #(
  parameter int unsigned HALF_CYC = 600,
  parameter int unsigned IDLE_CYC = 100000
) (
  input logic      clk,
  input logic      rst,
  jp_scan_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_CLK_HI, S_CLK_LO, S_DONE, S_WAIT
  } state_t;

  localparam logic [16:0] LatchLast = 17'(2 * HALF_CYC - 1);
  localparam logic [16:0] HalfLast  = 17'(HALF_CYC - 1);
  localparam logic [23:0] GapInit   = 24'(IDLE_CYC);

  state_t      state_q, state_d;
  logic [16:0] phase_q, phase_d;
  logic [23:0] gap_q, gap_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  raw1_q, raw1_d, raw2_q, raw2_d;
  logic [7:0]  st1_q, st1_d, st2_q, st2_d;
  logic        pend_q, pend_d;
  logic        latch_q, clk_q, vld_q, busy_q;
  logic        phase_last, scan_busy;

  assign phase_last = (phase_q == 17'd0);
  assign scan_busy  = (state_q == S_LATCH) || (state_q == S_CLK_HI) ||
                      (state_q == S_CLK_LO) || (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    raw1_d  = raw1_q;
    raw2_d  = raw2_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.scan_req || bus.auto_en) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (phase_last) begin
          raw1_d[0] = ~bus.jp_data1;
          raw2_d[0] = ~bus.jp_data2;
          idx_d     = 3'd1;
          state_d   = S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (phase_last) state_d = S_CLK_LO;
      end
      S_CLK_LO: begin
        if (phase_last) begin
          raw1_d[idx_q] = ~bus.jp_data1;
          raw2_d[idx_q] = ~bus.jp_data2;
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_CLK_HI;
          end
        end
      end
      S_DONE: begin
        // A request arriving in this very cycle counts as pending.
        if (pend_q || bus.scan_req) state_d = S_LATCH;
        else if (bus.auto_en)       state_d = S_WAIT;
        else                        state_d = S_IDLE;
      end
      S_WAIT: begin
        if (bus.scan_req)        state_d = S_LATCH;
        else if (!bus.auto_en)   state_d = S_IDLE;
        else if (gap_q == 24'd0) state_d = S_LATCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters count down to zero and reload whenever the state changes.
  always_comb begin
    phase_d = phase_last ? 17'd0 : phase_q - 17'd1;
    gap_d   = (gap_q == 24'd0) ? 24'd0 : gap_q - 24'd1;
    if (state_d != state_q) begin
      gap_d = GapInit;
      case (state_d)
        S_LATCH:           phase_d = LatchLast;
        S_CLK_HI, S_CLK_LO: phase_d = HalfLast;
        default:           phase_d = 17'd0;
      endcase
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (state_d == S_LATCH && state_q != S_LATCH) pend_d = 1'b0;
    else if (bus.scan_req && scan_busy)           pend_d = 1'b1;
  end

`ifdef JP_SCAN_DEBOUNCE_EN
  logic [7:0] prev1_q, prev1_d, prev2_q, prev2_d;

  always_comb begin
    st1_d   = st1_q;
    st2_d   = st2_q;
    prev1_d = prev1_q;
    prev2_d = prev2_q;
    if (state_d == S_DONE) begin
      if (raw1_d == prev1_q) st1_d = raw1_d;
      if (raw2_d == prev2_q) st2_d = raw2_d;
      prev1_d = raw1_d;
      prev2_d = raw2_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev1_q <= 8'h00;
      prev2_q <= 8'h00;
    end else begin
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
    end
  end
`else
  // raw_d already holds bit 7 when the DONE transition is taken.
  always_comb begin
    st1_d = st1_q;
    st2_d = st2_q;
    if (state_d == S_DONE) begin
      st1_d = raw1_d;
      st2_d = raw2_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 17'd0;
      gap_q   <= 24'd0;
      idx_q   <= 3'd0;
      raw1_q  <= 8'h00;
      raw2_q  <= 8'h00;
      st1_q   <= 8'h00;
      st2_q   <= 8'h00;
      pend_q  <= 1'b0;
      latch_q <= 1'b0;
      clk_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      raw1_q  <= raw1_d;
      raw2_q  <= raw2_d;
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      pend_q  <= pend_d;
      latch_q <= (state_d == S_LATCH);
      clk_q   <= (state_d == S_CLK_HI);
      vld_q   <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.jp_latch  = latch_q;
  assign bus.jp_clk    = clk_q;
  assign bus.jp1_state = st1_q;
  assign bus.jp2_state = st2_q;
  assign bus.state_vld = vld_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_jp_scan_ctrl.sv
// Bench for jp_scan_ctrl: shift-register joypad model, expected-state queue, vld-driven monitor.
module tb_jp_scan_ctrl;
  localparam int unsigned H   = 2;
  localparam int unsigned GAP = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  jp_scan_if bus ();

  jp_scan_ctrl #(.HALF_CYC(H), .IDLE_CYC(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Joypad model: reload on latch, advance one bit per jp_clk rising edge.
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00, sr1 = 8'h00, sr2 = 8'h00;
  int         idx_m = 8;
  logic       mclk_prev = 1'b0;

  always @(negedge clk) begin
    mclk_prev <= bus.jp_clk;
    if (bus.jp_latch) begin
      sr1   <= btn1;
      sr2   <= btn2;
      idx_m <= 0;
    end else if (bus.jp_clk && !mclk_prev && idx_m < 8) begin
      idx_m <= idx_m + 1;
    end
  end

  assign bus.jp_data1 = (idx_m < 8) ? ~sr1[idx_m[2:0]] : 1'b1;
  assign bus.jp_data2 = (idx_m < 8) ? ~sr2[idx_m[2:0]] : 1'b1;

  // Scoreboard
  typedef struct packed {
    logic [7:0] j1;
    logic [7:0] j2;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] m1 = 8'h00, m2 = 8'h00, p1 = 8'h00, p2 = 8'h00;

  task automatic expect_scan(input logic [7:0] r1, input logic [7:0] r2);
`ifdef JP_SCAN_DEBOUNCE_EN
    if (r1 == p1) m1 = r1;
    if (r2 == p2) m2 = r2;
    p1 = r1;
    p2 = r2;
`else
    m1 = r1;
    m2 = r2;
`endif
    expq.push_back('{j1: m1, j2: m2});
  endtask

  // Monitor
  int         vld_n = 0;
  int         vld_cyc[$];
  int         lat_rise_n = 0;
  int         lat_rise_cyc[$];
  int         lat_len = 0, clk_rises = 0, clk_hi = 0, bad = 0;
  logic       lat_prev = 1'b0, clk_prev = 1'b0;
  logic [7:0] st1_prev = 8'h00, st2_prev = 8'h00;

  always @(negedge clk) begin
    st1_prev <= bus.jp1_state;
    st2_prev <= bus.jp2_state;
    lat_prev <= bus.jp_latch;
    clk_prev <= bus.jp_clk;
    if (rst) begin
      lat_len   <= 0;
      clk_rises <= 0;
      clk_hi    <= 0;
    end else begin
      if (bus.jp_latch && bus.jp_clk) bad <= bad + 1;
      if (!bus.busy && (bus.jp_latch || bus.jp_clk)) bad <= bad + 1;
      if (!bus.state_vld && (bus.jp1_state != st1_prev || bus.jp2_state != st2_prev))
        bad <= bad + 1;
      if (bus.jp_latch && !lat_prev) begin
        lat_rise_cyc.push_back(cyc);
        lat_rise_n <= lat_rise_n + 1;
      end
      if (bus.state_vld) begin
        vld_cyc.push_back(cyc);
        vld_n <= vld_n + 1;
        if (expq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_vld: got state_vld with no scan expected (cycle %0d)", cyc);
        end else begin
          chk("jp1_state", int'(bus.jp1_state), int'(expq[0].j1));
          chk("jp2_state", int'(bus.jp2_state), int'(expq[0].j2));
          void'(expq.pop_front());
        end
        chk("latch_len", lat_len, 2 * H);
        chk("clk_pulses", clk_rises, 7);
        chk("clk_high_cycles", clk_hi, 7 * H);
        lat_len   <= 0;
        clk_rises <= 0;
        clk_hi    <= 0;
      end else begin
        lat_len   <= lat_len + int'(bus.jp_latch);
        clk_hi    <= clk_hi + int'(bus.jp_clk);
        clk_rises <= clk_rises + int'(bus.jp_clk && !clk_prev);
      end
    end
  end

  task automatic pulse_req(output int k);
    bus.scan_req = 1'b1;
    step();
    k = cyc;
    bus.scan_req = 1'b0;
  endtask

  task automatic wait_vld(input int target, input int budget);
    int t = 0;
    while (vld_n < target && t < budget) begin
      step();
      t++;
    end
    n_chk++;
    if (vld_n < target) begin
      n_err++;
      $display("FAIL vld_timeout: got %0d scans expected %0d", vld_n, target);
    end
  endtask

  initial begin
    int k;
    int t;
    int nl;
    bus.scan_req = 1'b0;
    bus.auto_en  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_latch", int'(bus.jp_latch), 0);
    chk("rst_clk", int'(bus.jp_clk), 0);
    chk("rst_jp1", int'(bus.jp1_state), 0);
    chk("rst_jp2", int'(bus.jp2_state), 0);
    chk("rst_vld", int'(bus.state_vld), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // Single scan, port 1 pressed only on bit 3
    btn1 = 8'h08;
    btn2 = 8'h00;
    expect_scan(btn1, btn2);
    pulse_req(k);
    wait_vld(1, 200);
    chk("scan_latency", vld_cyc[0] - k, 16 * H);
    step();
    chk("busy_after_done", int'(bus.busy), 0);

    // All buttons on port 2
    btn1 = 8'hA5;
    btn2 = 8'hFF;
    expect_scan(btn1, btn2);
    pulse_req(k);
    wait_vld(2, 200);

    // Two requests during one scan merge into one extra scan
    btn1 = 8'h3C;
    btn2 = 8'hC3;
    expect_scan(btn1, btn2);
    expect_scan(btn1, btn2);
    pulse_req(k);
    repeat (5) step();
    pulse_req(k);
    repeat (5) step();
    pulse_req(k);
    wait_vld(4, 300);
    chk("pending_latch_gap", lat_rise_cyc[lat_rise_cyc.size() - 1] - vld_cyc[2], 1);
    repeat (60) step();
    chk("no_extra_scan", vld_n, 4);

    // Reset in the middle of a clock-high phase
    btn1 = 8'h77;
    btn2 = 8'h11;
    pulse_req(k);
    t = 0;
    while (!bus.jp_clk && t < 100) begin
      step();
      t++;
    end
    chk("reached_clk_hi", int'(bus.jp_clk), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_clk", int'(bus.jp_clk), 0);
    chk("mid_rst_latch", int'(bus.jp_latch), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_jp1", int'(bus.jp1_state), 0);
    chk("mid_rst_jp2", int'(bus.jp2_state), 0);
    chk("mid_rst_vld", int'(bus.state_vld), 0);
    repeat (2) step();
    rst = 1'b0;
    m1 = 8'h00;
    m2 = 8'h00;
    p1 = 8'h00;
    p2 = 8'h00;
    repeat (40) step();
    chk("no_vld_after_rst", vld_n, 4);

    // Repeat/change pattern sequence (exercises the debounce path when built)
    btn1 = 8'h01;
    btn2 = 8'h00;
    expect_scan(btn1, btn2);
    pulse_req(k);
    wait_vld(5, 200);
    expect_scan(btn1, btn2);
    pulse_req(k);
    wait_vld(6, 200);
    btn1 = 8'h02;
    expect_scan(btn1, btn2);
    pulse_req(k);
    wait_vld(7, 200);
    repeat (3) step();

    // Free-running mode
    btn1 = 8'h81;
    btn2 = 8'h18;
    expect_scan(btn1, btn2);
    expect_scan(btn1, btn2);
    expect_scan(btn1, btn2);
    bus.auto_en = 1'b1;
    wait_vld(10, 600);
    chk("auto_period_a", vld_cyc[8] - vld_cyc[7], 16 * H + GAP + 2);
    chk("auto_period_b", vld_cyc[9] - vld_cyc[8], 16 * H + GAP + 2);
    repeat (3) step();
    chk("busy_in_wait", int'(bus.busy), 1);
    nl = lat_rise_n;
    bus.auto_en = 1'b0;
    step();
    chk("busy_drop", int'(bus.busy), 0);
    repeat (80) step();
    chk("auto_stop_vld", vld_n, 10);
    chk("auto_stop_latch", lat_rise_n, nl);

    chk("protocol_bad_cycles", bad, 0);
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
